// File: rtl/sand_line_fetcher.sv
// Row prefetcher and palette stage for the falling-sand VGA output.
// Prefetches one grid row per cell-line during hblank into a ping-pong line buffer.
module sand_line_fetcher #(
  parameter int GRID_W     = 160,
  parameter int GRID_H     = 120,
  parameter int CELL_SHIFT = 2,
  parameter int CELL_BITS  = 3,
  parameter int ADDR_W     = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [CELL_BITS-1:0] mem_rdata,
  output logic [7:0]           pix_r,
  output logic [7:0]           pix_g,
  output logic [7:0]           pix_b,
  output logic                 overrun
);

  localparam int          IDX_W    = $clog2(GRID_W);
  localparam logic [10:0] H_ACTIVE = 11'(GRID_W << (CELL_SHIFT + 1));
  localparam logic [10:0] H_LAST   = 11'd1599;
  localparam logic [9:0]  V_ACTIVE = 10'(GRID_H << CELL_SHIFT);
  localparam logic [9:0]  V_LAST   = 10'd524;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [23:0] C_EMPTY = 24'h999999;
  localparam logic [23:0] C_SAND  = 24'hC2B280;
  localparam logic [23:0] C_WATER = 24'h2040FF;
  localparam logic [23:0] C_WALL  = 24'h808080;
  localparam logic [23:0] C_FIRE  = 24'hFF6000;
  localparam logic [23:0] C_DEBUG = 24'hFF00FF;

  logic [1:0]           state_q, state_d;
  logic                 issue_q, issue_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 rv_q, rv_d;
  logic [IDX_W-1:0]     ridx_q, ridx_d;
  logic                 sel_q, sel_d;
  logic                 row_valid_q, row_valid_d;
  logic                 overrun_q, overrun_d;

  logic [CELL_BITS-1:0] buf0_q [GRID_W];
  logic [CELL_BITS-1:0] buf1_q [GRID_W];

  logic [9:0]           next_line;
  logic                 fetch_due;
  logic [ADDR_W-1:0]    row_ext;
  logic [ADDR_W-1:0]    base;
  logic                 start;
  logic [IDX_W-1:0]     cur_idx;
  logic                 accept;
  logic                 complete;
  logic                 line_end;
  logic                 in_fetch;
  logic                 abort;
  logic                 swap;
  logic                 wr_en;

  always_comb begin
    next_line = (vcount == V_LAST) ? '0 : vcount + 10'd1;
    fetch_due = (next_line < V_ACTIVE) && (next_line[CELL_SHIFT-1:0] == '0);
    row_ext   = ADDR_W'(next_line >> CELL_SHIFT);
    base      = (row_ext << 7) + (row_ext << 5);
  end

  // The first request goes out combinationally on hcount==1280 so a fetch
  // throttled to every other cycle still lands its last return by 1599.
  always_comb begin
    line_end = (hcount == H_LAST);
    in_fetch = (state_q == S_FETCH);
    start    = !reset && (state_q == S_IDLE) && (hcount == H_ACTIVE) && fetch_due;
    mem_req  = issue_q | start;
    mem_addr = start ? base : addr_q;
    cur_idx  = start ? '0 : idx_q;
    accept   = mem_req & mem_gnt;
    complete = rv_q && (ridx_q == LAST_IDX);
    abort    = in_fetch && line_end && !complete;
    swap     = line_end && ((state_q == S_DONE) || (in_fetch && complete));
    wr_en    = rv_q && !abort;
  end

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    rv_d        = 1'b0;
    ridx_d      = ridx_q;
    sel_d       = sel_q;
    row_valid_d = row_valid_q;
    overrun_d   = overrun_q;

    if (start) begin
      state_d = S_FETCH;
      issue_d = 1'b1;
      idx_d   = '0;
      addr_d  = base;
    end
    if (accept) begin
      idx_d   = cur_idx + IDX_W'(1);
      addr_d  = mem_addr + ADDR_W'(1);
      issue_d = (cur_idx != LAST_IDX);
      rv_d    = 1'b1;
      ridx_d  = cur_idx;
    end
    if (in_fetch && complete) begin
      state_d = S_DONE;
    end
    if (swap) begin
      sel_d       = ~sel_q;
      row_valid_d = 1'b1;
      state_d     = S_IDLE;
    end
    if (abort) begin
      state_d   = S_IDLE;
      issue_d   = 1'b0;
      rv_d      = 1'b0;
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      issue_q     <= 1'b0;
      idx_q       <= '0;
      addr_q      <= '0;
      rv_q        <= 1'b0;
      ridx_q      <= '0;
      sel_q       <= 1'b0;
      row_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      rv_q        <= rv_d;
      ridx_q      <= ridx_d;
      sel_q       <= sel_d;
      row_valid_q <= row_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign overrun = overrun_q;

  // Back buffer is the half not selected for display (sel_q=0 shows buf0).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (sel_q) begin
        buf0_q[ridx_q] <= mem_rdata;
      end else begin
        buf1_q[ridx_q] <= mem_rdata;
      end
    end
  end

  logic [9:0]           col_full;
  logic                 col_in_range;
  logic [IDX_W-1:0]     col_idx;
  logic [CELL_BITS-1:0] rd_cell;
  logic                 s1_act_d;

  always_comb begin
    col_full     = hcount[10:1] >> CELL_SHIFT;
    col_in_range = (col_full < 10'(GRID_W));
    col_idx      = col_in_range ? IDX_W'(col_full) : '0;
    rd_cell      = sel_q ? buf1_q[col_idx] : buf0_q[col_idx];
    s1_act_d     = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
  end

  logic [CELL_BITS-1:0] s1_cell_q;
  logic                 s1_act_q;
  logic                 s1_vld_q;
  logic [23:0]          pal_rgb;
  logic [23:0]          pix_d;
  logic [23:0]          pix_q;

  always_comb begin
    pal_rgb = C_DEBUG;
    case (s1_cell_q)
      CELL_BITS'(0): pal_rgb = C_EMPTY;
      CELL_BITS'(1): pal_rgb = C_SAND;
      CELL_BITS'(2): pal_rgb = C_WATER;
      CELL_BITS'(3): pal_rgb = C_WALL;
      CELL_BITS'(4): pal_rgb = C_FIRE;
      default:       pal_rgb = C_DEBUG;
    endcase
    if (!s1_act_q) begin
      pix_d = '0;
    end else if (!s1_vld_q) begin
      pix_d = C_EMPTY;
    end else begin
      pix_d = pal_rgb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_cell_q <= '0;
      s1_act_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      pix_q     <= '0;
    end else begin
      s1_cell_q <= rd_cell;
      s1_act_q  <= s1_act_d;
      s1_vld_q  <= row_valid_q;
      pix_q     <= pix_d;
    end
  end

  assign pix_r = pix_q[23:16];
  assign pix_g = pix_q[15:8];
  assign pix_b = pix_q[7:0];

endmodule

// File: tb/tb_sand_line_fetcher.sv
// Self-checking bench for sand_line_fetcher: scans selected video lines with
// a grid RAM responder and a line-level model of fetch, overrun and display.
module tb_sand_line_fetcher;

  localparam int GRID_W    = 160;
  localparam int GRID_H    = 120;
  localparam int CELL_BITS = 3;
  localparam int ADDR_W    = 15;
  localparam int RAM_SZ    = GRID_W * GRID_H;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [10:0]          hcount;
  logic [9:0]           vcount;
  logic                 mem_req;
  logic                 mem_gnt;
  logic [ADDR_W-1:0]    mem_addr;
  logic [CELL_BITS-1:0] mem_rdata;
  logic [7:0]           pix_r, pix_g, pix_b;
  logic                 overrun;

  always #5 clk = ~clk;

  sand_line_fetcher #(
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H),
    .CELL_SHIFT(2),
    .CELL_BITS (CELL_BITS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .hcount   (hcount),
    .vcount   (vcount),
    .mem_req  (mem_req),
    .mem_gnt  (mem_gnt),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .pix_r    (pix_r),
    .pix_g    (pix_g),
    .pix_b    (pix_b),
    .overrun  (overrun)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (h=%0d v=%0d)", tag, got, exp, hcount, vcount);
    end
  endtask

  logic [2:0]  ram   [RAM_SZ];
  logic [2:0]  m_row [GRID_W];
  logic [23:0] pal   [8];
  bit          m_valid;
  bit          m_ovr;
  logic [23:0] exp_d1, exp_d2;
  bit          pend;
  int          pend_addr;

  function automatic logic [23:0] exp_pix(input int h, input int v);
    if (!(h < 1280 && v < 480)) return 24'h000000;
    if (!m_valid) return 24'h999999;
    return pal[m_row[h / 8]];
  endfunction

  // gmode: 0 grant always, 1 grant on even hcount, 2 grant from hcount 1500,
  // otherwise the percentage chance of a grant on each cycle.
  task automatic run_line(input int v, input int gmode, input int rst_at);
    int nl, base, g, g_end;
    bit due, fetching, exp_req;
    nl   = (v == 524) ? 0 : v + 1;
    due  = (nl < 480) && (nl % 4 == 0);
    base = (nl / 4) * GRID_W;
    fetching = 1'b0;
    g = 0;
    g_end = 0;
    for (int h = 0; h < 1600; h++) begin
      @(posedge clk);
      #1;
      hcount = 11'(h);
      vcount = 10'(v);
      case (gmode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = (h % 2 == 0);
        2:       mem_gnt = (h >= 1500);
        default: mem_gnt = ($urandom_range(0, 99) < gmode);
      endcase
      mem_rdata = pend ? ram[pend_addr] : 3'($urandom);
      if (rst_at >= 0 && h == rst_at) reset = 1'b1;
      else if (rst_at >= 0 && h == rst_at + 2) reset = 1'b0;
      if (reset) begin
        fetching = 1'b0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        exp_d1   = '0;
        exp_d2   = '0;
      end else if (due && h == 1280) begin
        fetching = 1'b1;
      end

      @(negedge clk);
      exp_req = fetching && (g < GRID_W);
      check("mem_req", mem_req, exp_req);
      if (exp_req) check("mem_addr", mem_addr, base + g);
      check("overrun", overrun, m_ovr);
      check("pixel", {pix_r, pix_g, pix_b}, exp_d2);

      pend      = mem_req && mem_gnt && !reset;
      pend_addr = (int'(mem_addr) < RAM_SZ) ? int'(mem_addr) : 0;
      if (h == 1599) g_end = g;
      if (exp_req && mem_gnt) g++;
      exp_d2 = exp_d1;
      exp_d1 = reset ? 24'h000000 : exp_pix(h, v);

      // A row becomes visible only if all 160 addresses were granted by 1598.
      if (h == 1599 && fetching) begin
        if (g_end == GRID_W) begin
          for (int c = 0; c < GRID_W; c++) m_row[c] = ram[base + c];
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pct;
    pal[0] = 24'h999999; pal[1] = 24'hC2B280; pal[2] = 24'h2040FF; pal[3] = 24'h808080;
    pal[4] = 24'hFF6000; pal[5] = 24'hFF00FF; pal[6] = 24'hFF00FF; pal[7] = 24'hFF00FF;
    for (int a = 0; a < RAM_SZ; a++) ram[a] = 3'($urandom_range(0, 7));
    for (int c = 0; c < GRID_W; c++) ram[c] = 3'(c % 5);
    for (int c = 0; c < GRID_W; c++) m_row[c] = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    exp_d1  = '0;
    exp_d2  = '0;
    pend    = 1'b0;
    pend_addr = 0;

    reset     = 1'b1;
    hcount    = 11'd1500;
    vcount    = 10'd500;
    mem_gnt   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pixel", {pix_r, pix_g, pix_b}, 24'h000000);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b0;

    run_line(100, 0, -1);
    run_line(524, 0, -1);
    run_line(0, 0, -1);
    run_line(3, 0, -1);
    run_line(4, 0, -1);
    run_line(5, 0, -1);
    run_line(6, 0, -1);
    run_line(475, 0, -1);
    run_line(476, 0, -1);
    run_line(7, 1, -1);
    run_line(8, 0, -1);
    run_line(11, 2, -1);
    run_line(12, 0, -1);
    run_line(15, 0, -1);
    run_line(16, 0, -1);

    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(0, 118);
      case (n % 4)
        0:       pct = 0;
        1:       pct = 75;
        2:       pct = 55;
        default: pct = 40;
      endcase
      run_line(4 * k + 3, pct, -1);
      run_line(4 * k + 4, 0, -1);
    end

    run_line(19, 0, 1350);
    run_line(20, 0, -1);
    run_line(23, 0, -1);
    run_line(24, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
